// File: rtl/neunet_mm_csr_bridge.sv
// -----------------------------------------------------------------------------
// neunet_mm_csr_bridge
//
// Avalon-MM slave that fronts the neural-net accelerator. It holds the
// command/status register, an auto-incrementing working pointer (wp), an input
// pointer, NUM_PTRS layer base pointers, a layer-size register and an
// interrupt enable. The data port (address 1) reaches the shared RAM through
// a request/grant port on the RAM arbiter. A START command pulses the
// feed-forward controller, and its done pulse raises a maskable interrupt.
//
// Register map (avs_address):
//   0  W: command {arg[15:8], opcode[7:0]}
//      R: status {.., irq_pend, cmd_err, busy, done_st}
//   1  data port: RAM[wp], wp auto-increments after each access
//   2  working pointer (RO)      3  input pointer (RO)
//   4  layer sizes (RW)          5  irq_en in bit 0 (RW)
//   8..8+NUM_PTRS-1  base pointers (RO); anything else reads 0
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   avs_*                 Avalon-MM slave (address, chipselect, read, write,
//                         writedata, readdata, waitrequest)
//   ram_req/ram_gnt       arbiter handshake; the access happens in the grant
//                         cycle
//   ram_wen, ram_addr,    write qualifier, address (= wp), write data
//   ram_wdata             (= avs_writedata)
//   ram_rdata             RAM read data, valid RD_LATENCY cycles after grant
//   start, done           controller start pulse / completion pulse
//   base_ptrs, act_ptr,   controller configuration; base entry i sits at
//   layer_sizes           [i*RAM_AW +: RAM_AW]
//   irq                   level interrupt = done_st & irq_en
//
// DATA_W must be at least 32 (command and layer-size fields).
// -----------------------------------------------------------------------------
module neunet_mm_csr_bridge #(
  parameter int DATA_W     = 32,
  parameter int RAM_AW     = 16,
  parameter int NUM_PTRS   = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 avs_address,
  input  logic                       avs_chipselect,
  input  logic                       avs_read,
  input  logic                       avs_write,
  input  logic [DATA_W-1:0]          avs_writedata,
  output logic [DATA_W-1:0]          avs_readdata,
  output logic                       avs_waitrequest,
  output logic                       ram_req,
  input  logic                       ram_gnt,
  output logic                       ram_wen,
  output logic [RAM_AW-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_wdata,
  input  logic [DATA_W-1:0]          ram_rdata,
  output logic                       start,
  input  logic                       done,
  output logic [NUM_PTRS*RAM_AW-1:0] base_ptrs,
  output logic [RAM_AW-1:0]          act_ptr,
  output logic [31:0]                layer_sizes,
  output logic                       irq
);

  localparam int LAT_W = 3;

  localparam logic [7:0] OP_CLEAR     = 8'h01;
  localparam logic [7:0] OP_SAVE_BASE = 8'h02;
  localparam logic [7:0] OP_SAVE_IN   = 8'h03;
  localparam logic [7:0] OP_REWIND    = 8'h04;
  localparam logic [7:0] OP_ALIGN4    = 8'h05;
  localparam logic [7:0] OP_START     = 8'h06;
  localparam logic [7:0] OP_ADV1      = 8'h07;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t             r_state, w_state_nxt;
  logic [LAT_W-1:0]   r_lat, w_lat_nxt;

  logic [RAM_AW-1:0]  r_wp;
  logic [RAM_AW-1:0]  r_in;
  logic [RAM_AW-1:0]  r_base [NUM_PTRS];
  logic [31:0]        r_layer;
  logic               r_irq_en;
  logic               r_done_st;
  logic               r_busy;
  logic               r_cmd_err;
  logic               r_start;

  logic               w_access, w_dp, w_dp_rd, w_dp_wr, w_reg_wr;
  logic               w_req, w_wen, w_wait, w_wr_fin, w_rd_fin, w_wp_inc;
  logic               w_busy_eff;
  logic [7:0]         w_opcode, w_arg;
  logic [DATA_W-1:0]  w_reg_rdata;

  assign w_access = avs_chipselect & (avs_read | avs_write);
  assign w_dp     = (avs_address == 4'd1);
  assign w_dp_wr  = avs_chipselect & avs_write & w_dp;
  assign w_dp_rd  = avs_chipselect & avs_read & ~avs_write & w_dp;
  // Register accesses are only taken while no data-port access is in flight;
  // otherwise they are stalled until the FSM is back in IDLE.
  assign w_reg_wr = avs_chipselect & avs_write & ~w_dp & (r_state == S_IDLE);

  assign w_opcode = avs_writedata[7:0];
  assign w_arg    = avs_writedata[15:8];

  // A done pulse frees the engine in the same cycle, so a START or CLEAR
  // arriving alongside it is accepted (CLEAR then overrides the done update).
  assign w_busy_eff = r_busy & ~done;

  // Master abandoning a stalled read: the RAM access still completes but the
  // pointer only advances if the read is still being presented.
  assign w_wp_inc = w_wr_fin | (w_rd_fin & w_dp_rd);

  // ---------------------------------------------------------------------------
  // Data-port FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (reset) begin
      r_state <= S_IDLE;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lat   <= w_lat_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat;
    w_req       = 1'b0;
    w_wen       = 1'b0;
    w_wait      = 1'b0;
    w_wr_fin    = 1'b0;
    w_rd_fin    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Writes need no FSM: the request is held combinationally until the
        // grant cycle, which is also the cycle the write completes.
        if (w_dp_wr) begin
          w_req    = 1'b1;
          w_wen    = 1'b1;
          w_wait   = ~ram_gnt;
          w_wr_fin = ram_gnt;
        end else if (w_dp_rd) begin
          w_req  = 1'b1;
          w_wait = 1'b1;
          if (ram_gnt) begin
            w_state_nxt = S_WAIT;
            w_lat_nxt   = LAT_W'(1);
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        // Request stays up even if the master walks away; the access finishes.
        w_req  = 1'b1;
        w_wait = w_access;
        if (ram_gnt) begin
          w_state_nxt = S_WAIT;
          w_lat_nxt   = LAT_W'(1);
        end
      end
      S_WAIT: begin
        // r_lat counts cycles since the grant; RAM data is valid when it
        // reaches RD_LATENCY, which is the cycle waitrequest drops.
        if (r_lat == LAT_W'(RD_LATENCY)) begin
          w_state_nxt = S_IDLE;
          w_rd_fin    = 1'b1;
          w_wait      = w_access & ~w_dp_rd;
        end else begin
          w_lat_nxt = r_lat + LAT_W'(1);
          w_wait    = w_access;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reset must withdraw the RAM request and the stall at once, not at an edge.
  assign ram_req         = w_req & ~reset;
  assign avs_waitrequest = w_wait & ~reset;
  assign ram_wen         = w_wen;
  assign ram_addr        = r_wp;
  assign ram_wdata       = avs_writedata;

  // ---------------------------------------------------------------------------
  // Registers and command execution
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp      <= '0;
      r_in      <= '0;
      r_layer   <= '0;
      r_irq_en  <= 1'b0;
      r_done_st <= 1'b0;
      r_busy    <= 1'b0;
      r_cmd_err <= 1'b0;
      r_start   <= 1'b0;
      // NOTE: the base-pointer array is a handful of flops, not a RAM, so it
      // is reset like any other register.
      for (int i = 0; i < NUM_PTRS; i++) r_base[i] <= '0;
    end else begin
      r_start <= 1'b0;
      if (done) begin
        r_done_st <= 1'b1;
        r_busy    <= 1'b0;
      end
      if (w_wp_inc) r_wp <= r_wp + RAM_AW'(1);
      // Later assignments below override the done update (CLEAR wins).
      if (w_reg_wr) begin
        case (avs_address)
          4'd0: begin
            case (w_opcode)
              OP_CLEAR: begin
                if (w_busy_eff) begin
                  r_cmd_err <= 1'b1;
                end else begin
                  r_wp      <= '0;
                  r_in      <= '0;
                  r_layer   <= '0;
                  r_irq_en  <= 1'b0;
                  r_done_st <= 1'b0;
                  r_busy    <= 1'b0;
                  r_cmd_err <= 1'b0;
                  for (int i = 0; i < NUM_PTRS; i++) r_base[i] <= '0;
                end
              end
              OP_SAVE_BASE: begin
                if (w_arg >= 8'(NUM_PTRS)) begin
                  r_cmd_err <= 1'b1;
                end else begin
                  for (int i = 0; i < NUM_PTRS; i++)
                    if (w_arg == 8'(i)) r_base[i] <= r_wp;
                end
              end
              OP_SAVE_IN: r_in <= r_wp;
              OP_REWIND:  r_wp <= r_in;
              OP_ALIGN4:  r_wp <= (r_wp + RAM_AW'(4)) & ~RAM_AW'(3);
              OP_START: begin
                if (w_busy_eff) begin
                  r_cmd_err <= 1'b1;
                end else begin
                  r_start   <= 1'b1;
                  r_busy    <= 1'b1;
                  r_done_st <= 1'b0;
                end
              end
              OP_ADV1:    r_wp <= r_wp + RAM_AW'(1);
              default:    r_cmd_err <= 1'b1;
            endcase
          end
          4'd4:    r_layer  <= 32'(avs_writedata);
          4'd5:    r_irq_en <= avs_writedata[0];
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path and controller outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_reg_rdata = '0;
    case (avs_address)
      4'd0:    w_reg_rdata = DATA_W'({irq, r_cmd_err, r_busy, r_done_st});
      4'd2:    w_reg_rdata = DATA_W'(r_wp);
      4'd3:    w_reg_rdata = DATA_W'(r_in);
      4'd4:    w_reg_rdata = DATA_W'(r_layer);
      4'd5:    w_reg_rdata = DATA_W'(r_irq_en);
      default: begin
        for (int i = 0; i < NUM_PTRS; i++)
          if (avs_address == 4'(8 + i)) w_reg_rdata = DATA_W'(r_base[i]);
      end
    endcase
  end

  always_comb begin
    avs_readdata = '0;
    if (w_rd_fin)
      avs_readdata = ram_rdata;
    else if (avs_chipselect & avs_read & ~w_dp)
      avs_readdata = w_reg_rdata;
  end

  always_comb begin
    base_ptrs = '0;
    for (int i = 0; i < NUM_PTRS; i++) base_ptrs[i*RAM_AW +: RAM_AW] = r_base[i];
  end

  assign start       = r_start;
  assign act_ptr     = r_in;
  assign layer_sizes = r_layer;
  assign irq         = r_done_st & r_irq_en;

endmodule

// File: doc/neunet_mm_csr_bridge.md
# neunet_mm_csr_bridge

Parametrised Avalon-MM slave for the neural-net accelerator. It holds a command/status register, a working pointer with auto-increment on both data-port reads and writes, an input pointer, and NUM_PTRS layer base pointers. It reaches the quad-port RAM through a request/grant port on the RAM arbiter, where it has slave priority. It drives the feed-forward controller with a start pulse, base pointers and layer sizes, and raises a maskable done interrupt.

## Interface
- DATA_W, 32, Avalon and RAM data width.
- RAM_AW, 16, RAM word-address width; all pointers are RAM_AW bits.
- NUM_PTRS, 4, number of base-pointer registers; legal range 1..8.
- RD_LATENCY, 1, RAM read latency in cycles after grant; legal range 1..4.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- avs_address  in  4  register index.
- avs_chipselect, avs_read, avs_write  in  1 each  Avalon controls.
- avs_writedata  in  DATA_W  write data.
- avs_readdata  out  DATA_W  read data; valid only when waitrequest is low.
- avs_waitrequest  out  1  stall.
- ram_req  out  1  RAM access request.
- ram_gnt  in  1  arbiter grant; the access occurs in the grant cycle.
- ram_wen  out  1  write-not-read qualifier.
- ram_addr  out  RAM_AW  equals the working pointer.
- ram_wdata  out  DATA_W  equals avs_writedata.
- ram_rdata  in  DATA_W  RAM read data.
- start  out  1  one-cycle compute start.
- done  in  1  controller completion pulse.
- base_ptrs  out  NUM_PTRS*RAM_AW  flattened base pointers; entry i at [i*RAM_AW +: RAM_AW].
- act_ptr  out  RAM_AW  input pointer.
- layer_sizes  out  32  size register.
- irq  out  1  level interrupt.

## Operation
- Register map:
  - 0: write = command, read = status {28'b0, irq_pend, cmd_err, busy, done_st}.
  - 1: data port.
  - 2: working pointer wp, read-only.
  - 3: input pointer, read-only.
  - 4: layer sizes, read/write.
  - 5: irq_en[0], read/write.
  - 8..8+NUM_PTRS-1: base pointers, read-only.
  - Unmapped reads return 0; unmapped writes are ignored.
- Command word: opcode = writedata[7:0], argument = writedata[15:8].
  - 0x01 CLEAR: all registers, status, wp and pointers go to 0.
  - 0x02 SAVE_BASE: base[arg] <= wp. If arg >= NUM_PTRS, set cmd_err and leave the pointers unchanged.
  - 0x03 SAVE_IN: input pointer <= wp.
  - 0x04 REWIND: wp <= input pointer.
  - 0x05 ALIGN4: wp <= (wp+4) & ~3.
  - 0x06 START: pulse start, set busy, clear done_st.
  - 0x07 ADV1: wp <= wp+1.
  - Any other opcode: set cmd_err only.
- START while busy and CLEAR while busy are rejected: set cmd_err, no other effect.
- cmd_err is sticky; cleared only by CLEAR or reset.
- done pulse: done_st <= 1, busy <= 0. irq_pend = done_st & irq_en; irq = irq_pend.
- A done pulse in the same cycle as CLEAR: CLEAR wins.
- Data port write: hold ram_req=1 and ram_wen=1 until ram_gnt. wp increments by 1 after the grant cycle.
- Data port read: states IDLE -> REQ (ram_req=1, ram_wen=0) -> WAIT (count RD_LATENCY) -> IDLE.
  - readdata = ram_rdata in the final cycle.
  - wp increments by 1 at completion.
- Only one data-port access is outstanding at a time. Commands are not accepted mid data-port access, which is inherent to Avalon stalling.
- ADV1, ALIGN4 and auto-increment are modulo 2^RAM_AW; wrap-around is silent.
- All pointers read back zero-extended to DATA_W.

## Timing
- Reset values: every register 0, FSM in IDLE, readdata 0, waitrequest 0, ram_req 0, start 0, irq 0, outputs 0.
- Reset mid-access aborts the access with no wp increment. ram_req drops immediately.
- Register accesses (address != 1) have zero wait states:
  - waitrequest = 0 combinationally.
  - Read data is combinational from the registers.
  - Writes take effect at the next edge.
- start rises in the cycle after the START write edge and lasts exactly one cycle.
- Data-port write: waitrequest = chipselect & write & !ram_gnt. The write completes in the grant cycle.
- Data-port read:
  - waitrequest is high from the first request cycle through grant cycle g and the latency cycles.
  - It goes low in cycle g+RD_LATENCY, when readdata is valid.
  - Minimum read time is 1+RD_LATENCY cycles.
- ram_req deasserts the cycle after the grant.
- If the master drops chipselect while stalled, the FSM completes the RAM access but does not increment wp.

## Test plan
- Reset, then read every address -> all 0. waitrequest 0. irq 0.
- Write data port 3 times with ram_gnt tied 1 -> RAM words 0,1,2 written. wp=3. ALIGN4 -> wp=4. SAVE_BASE arg 2 -> reg10=4.
- ram_gnt delayed 5 cycles on a data-port read, RD_LATENCY=2 -> waitrequest high 7 cycles. Correct data in cycle 8. wp +1.
- SAVE_BASE arg NUM_PTRS, opcode 0x3F, START twice -> cmd_err=1, one start pulse, busy=1. CLEAR while busy -> rejected.
- irq_en=1, then a done pulse -> status=0x9, irq=1. CLEAR -> status 0, irq 0.
- wp=2^RAM_AW-1, then ADV1 -> 0. ALIGN4 from 2^RAM_AW-2 -> 0. Assert reset during a pending read -> FSM IDLE, wp unchanged at 0.
